// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: the mult/div
// occupancy FSM encoding, register-specifier width and the default
// mult/div latency.
package hazard_pkg;

  localparam int REG_W          = 5;
  localparam int MD_LATENCY_DEF = 4;
  localparam int CNT_W          = 4;

  // Register $zero never carries a real dependency.
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    IDLE   = 1'b0,
    MD_RUN = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_timer.sv
// Mult/div occupancy tracker. A start pulse in IDLE moves to MD_RUN and
// loads the down-counter with MD_LATENCY-1; the unit stays busy until the
// counter has reached zero, which gives exactly MD_LATENCY busy cycles.
// The current state is exported so the hazard logic can qualify stalls
// and starts, and so checkers can observe the FSM directly.
module md_timer
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      start,
  output logic      busy,
  output md_state_t state_dbg
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(MD_LATENCY - 1);

  md_state_t        state, state_n;
  logic [CNT_W-1:0] md_cnt, md_cnt_n;

  // State and counter registers; reset aborts any running operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_n;
      md_cnt <= md_cnt_n;
    end
  end

  // Next-state: load on start, count down while running, return on zero.
  always_comb begin
    state_n  = state;
    md_cnt_n = md_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = MD_RUN;
          md_cnt_n = LOAD;
        end
      end
      MD_RUN: begin
        if (md_cnt == '0) begin
          state_n = IDLE;
        end else begin
          md_cnt_n = md_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state == MD_RUN);
  assign state_dbg = state;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: PC enable,
// IF/ID hold/flush and ID/EX bubble insert, driven by EX redirects,
// load-use hazards and mult/div (HI/LO) occupancy, in that priority.
// All controls are combinational and act in the cycle of detection.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush counters.
//
// Handshake note: the IF/ID register only honours flush while hold is
// high, so every flush below is issued together with hold.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_md,
  input  logic             id_reads_hilo,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_redirect,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_start,
  output logic             md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  md_state_t md_state;
  logic      loaduse;
  logic      mdstall;

  md_timer #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (md_start),
    .busy     (md_busy),
    .state_dbg(md_state)
  );

  // Hazard detection and priority resolution; quiet while in reset.
  always_comb begin
    loaduse = ex_mem_read && (ex_rt != ZERO_REG) &&
              ((id_uses_rs && (id_rs == ex_rt)) ||
               (id_uses_rt && (id_rt == ex_rt)));
    mdstall = (md_state == MD_RUN) && (id_is_md || id_reads_hilo);

    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_start    = 1'b0;

    if (!reset) begin
      if (ex_redirect) begin
        // ID instruction is squashed, so its stalls are irrelevant.
        ifid_hold   = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (loaduse || mdstall) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end
      md_start = (md_state == IDLE) && id_is_md && !ex_redirect && !loaduse;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_hold && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (ifid_flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations,
// plus a per-cycle comparison against a behavioural model that tracks
// mult/div occupancy as a count of remaining busy cycles.
module tb_hazard_ctrl;

  localparam int L = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo, ex_mem_read, ex_redirect;
  logic pc_hold, ifid_hold, ifid_flush, idex_bubble, md_start, md_busy;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.MD_LATENCY(L)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_md     (id_is_md),
    .id_reads_hilo(id_reads_hilo),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .ex_redirect  (ex_redirect),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .md_start     (md_start),
    .md_busy      (md_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  wire [3:0] ctrl = {pc_hold, ifid_hold, ifid_flush, idex_bubble};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_is_md = 0; id_reads_hilo = 0;
    ex_mem_read = 0; ex_redirect = 0;
  endtask

  task automatic set_load(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] ert);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_mem_read = 1'b1; ex_rt = ert;
  endtask

  // ---------------- model + scoreboard ----------------
  logic [5:0] exp_q[$];
  int   rem = 0;          // remaining busy cycles of the mult/div unit
  logic m_lu, m_busy, m_start;
  logic [3:0] m_ctrl;
  logic [5:0] exp_v;
`ifdef HAZARD_STATS_EN
  int m_stall = 0;
  int m_flush = 0;
`endif

  always @(negedge clk) begin
    if (reset) begin
      rem     = 0;
      m_ctrl  = 4'b0000;
      m_start = 1'b0;
      m_busy  = 1'b0;
`ifdef HAZARD_STATS_EN
      m_stall = 0;
      m_flush = 0;
`endif
    end else begin
      m_lu = ex_mem_read && (ex_rt != 0) &&
             ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
      m_busy  = (rem > 0);
      m_start = !m_busy && id_is_md && !ex_redirect && !m_lu;
      if (ex_redirect)                              m_ctrl = 4'b0111;
      else if (m_lu)                                m_ctrl = 4'b1101;
      else if (m_busy && (id_is_md || id_reads_hilo)) m_ctrl = 4'b1101;
      else                                          m_ctrl = 4'b0000;
    end
    exp_q.push_back({m_start, m_busy, m_ctrl});

    exp_v = exp_q.pop_front();
    check("model_ctrl", {12'd0, ctrl}, {12'd0, exp_v[3:0]});
    check("model_start_busy", {14'd0, md_start, md_busy}, {14'd0, exp_v[5:4]});
    check("flush_implies_hold", {15'd0, ifid_flush & ~ifid_hold}, 16'd0);
`ifdef HAZARD_STATS_EN
    check("model_stall_cnt", stall_cnt, 16'(m_stall));
    check("model_flush_cnt", flush_cnt, 16'(m_flush));
    if (!reset) begin
      if (m_ctrl[3] && m_stall < 65535) m_stall++;
      if (m_ctrl[1] && m_flush < 65535) m_flush++;
    end
`endif

    if (!reset) begin
      if (m_start)      rem = L;
      else if (rem > 0) rem--;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  int busy_n, start_n;
  logic start5;

  initial begin
    reset = 1'b1;
    clear_in();
    // Hazard inputs active during reset must not produce controls.
    set_load(5'd8, 5'd0, 1'b1, 1'b0, 5'd8);
    id_is_md = 1'b1;
    #3;
    check("reset_ctrl", {12'd0, ctrl}, 16'd0);
    check("reset_md", {14'd0, md_start, md_busy}, 16'd0);
    tick(); tick();
    clear_in();
    reset = 1'b0;
    #3 check("after_release", {10'd0, md_start, md_busy, ctrl}, 16'd0);

    // Load-use on rs.
    tick(); set_load(5'd8, 5'd0, 1'b1, 1'b0, 5'd8);
    #3 check("loaduse_rs", {12'd0, ctrl}, 16'h000D);
    tick(); clear_in();
    #3 check("loaduse_cleared", {12'd0, ctrl}, 16'd0);
    // Same pattern on $zero: no dependency.
    tick(); set_load(5'd0, 5'd0, 1'b1, 1'b0, 5'd0);
    #3 check("loaduse_zero", {12'd0, ctrl}, 16'd0);
    // Load-use on rt.
    tick(); set_load(5'd3, 5'd9, 1'b0, 1'b1, 5'd9);
    #3 check("loaduse_rt", {12'd0, ctrl}, 16'h000D);
    // Matching specifier but not read.
    tick(); set_load(5'd8, 5'd0, 1'b0, 1'b0, 5'd8);
    #3 check("loaduse_unused", {12'd0, ctrl}, 16'd0);
    // Redirect with load-use: flush wins.
    tick(); set_load(5'd8, 5'd0, 1'b1, 1'b0, 5'd8); ex_redirect = 1'b1;
    #3 check("redirect_loaduse", {12'd0, ctrl}, 16'h0007);
    // Load-use suppresses a mult start.
    tick(); set_load(5'd8, 5'd0, 1'b1, 1'b0, 5'd8); id_is_md = 1'b1;
    #3 check("loaduse_blocks_start", {15'd0, md_start}, 16'd0);
    tick(); clear_in();

    // Mult then mfhi stalled for the whole occupancy.
    tick(); id_is_md = 1'b1;
    #3 check("mult_start", {10'd0, md_start, md_busy, ctrl}, 16'h0020);
    tick(); clear_in(); id_reads_hilo = 1'b1;
    for (int i = 0; i < L; i++) begin
      #3 check("mfhi_stall", {10'd0, md_start, md_busy, ctrl}, 16'h001D);
      tick();
    end
    #3 check("mfhi_go", {10'd0, md_start, md_busy, ctrl}, 16'd0);
    tick(); clear_in();

    // Redirect during MD_RUN does not abort the operation.
    tick(); id_is_md = 1'b1;
    tick(); clear_in(); ex_redirect = 1'b1;
    #3 check("redirect_in_run", {10'd0, md_start, md_busy, ctrl}, 16'h0017);
    tick(); clear_in();
    #3 check("run_continues", {15'd0, md_busy}, 16'd1);
    repeat (6) tick();

    // Back-to-back mult: 8 busy cycles, restart after one idle cycle.
    id_is_md = 1'b1;
    busy_n = 0; start_n = 0; start5 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #3;
      busy_n  += int'(md_busy);
      start_n += int'(md_start);
      if (i == 5) start5 = md_start;
      tick();
      if (i == 5) id_is_md = 1'b0;
    end
    check("b2b_busy_cycles", 16'(busy_n), 16'd8);
    check("b2b_starts", 16'(start_n), 16'd2);
    check("b2b_restart_gap", {15'd0, start5}, 16'd1);

    // Reset in the second MD_RUN cycle.
    tick(); id_is_md = 1'b1;
    #3 check("rst_run_start", {15'd0, md_start}, 16'd1);
    tick(); id_is_md = 1'b0;
    #3 check("rst_run_busy1", {15'd0, md_busy}, 16'd1);
    tick(); reset = 1'b1;
    #1 check("rst_mid_busy", {15'd0, md_busy}, 16'd0);
    tick(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3 check("rst_no_restart", {14'd0, md_start, md_busy}, 16'd0);
      tick();
    end
    id_is_md = 1'b1;
    #3 check("rst_new_start", {15'd0, md_start}, 16'd1);
    tick(); clear_in();
    repeat (6) tick();

`ifdef HAZARD_STATS_EN
    // Long load-use run saturates the stall counter.
    set_load(5'd8, 5'd0, 1'b1, 1'b0, 5'd8);
    repeat (70000) tick();
    #3 check("stall_saturate", stall_cnt, 16'hFFFF);
    tick(); clear_in();
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
